// File: rtl/spram_fifo_pkg.sv
// Shared types and constants for the single-port-RAM FIFO controller.
package spram_fifo_pkg;

    // Which side wins when both a write and a read want the RAM port.
    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_e;

    // The output buffer covers the one-cycle RAM read latency with two entries.
    localparam int OB_DEPTH = 2;
    localparam int OB_CW    = $clog2(OB_DEPTH + 1);

endpackage

// File: rtl/spram_fifo_obuf.sv
// Two-entry synchronous FIFO that holds RAM read data until the consumer takes it.
// Pushing while full or popping while empty is illegal; the parent guarantees neither happens.
module spram_fifo_obuf
    import spram_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OB_CW-1:0] cnt,
    output logic [WIDTH-1:0] head
);

    logic [OB_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic                           wr_q, wr_d;
    logic                           rd_q, rd_d;
    logic [OB_CW-1:0]               cnt_q, cnt_d;

    // Next-state: write at wr pointer, advance read pointer on pop, track occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + OB_CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - OB_CW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = mem_q[rd_q];

    // The read-request gate upstream reserves a slot for every read, so this cannot fire.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && cnt_q == OB_CW'(OB_DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && cnt_q == '0));

endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller driving one single-port RAM: writes and reads share the port
// with fair alternation, and a small output buffer hides the read latency.
module spram_fifo_ctrl
    import spram_fifo_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [LW-1:0]    level,
    output logic             mem_wen,
    output logic             mem_ren,
    output logic [AW-1:0]    mem_waddr,
    output logic [AW-1:0]    mem_raddr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
    logic             rd_inflight_q, rd_inflight_d;
    prio_e            prio_q, prio_d;

    logic [OB_CW-1:0] ob_cnt;
    logic [OB_CW:0]   ob_pending;
    logic             rd_req;
    logic             wr_go;
    logic             rd_go;
    logic             ob_pop;

    // Words already committed to the output buffer, including the one on its way from RAM.
    assign ob_pending = {1'b0, ob_cnt} + {{OB_CW{1'b0}}, rd_inflight_q};

    // Grant: a read only launches when the buffer has a slot reserved for it; when the
    // read has priority it blocks the write slot, which keeps push_ready free of input paths.
    always_comb begin
        rd_req     = (ram_cnt_q != '0) && (ob_pending < (OB_CW + 1)'(OB_DEPTH));
        push_ready = (ram_cnt_q != CW'(DEPTH)) && !(rd_req && prio_q == PRIO_READ);
        wr_go      = push_valid && push_ready;
        rd_go      = rd_req && !wr_go;
    end

    // Next-state for pointers, RAM occupancy, in-flight flag and arbitration priority.
    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        ram_cnt_d     = ram_cnt_q;
        prio_d        = prio_q;
        rd_inflight_d = rd_go;
        if (wr_go) begin
            wptr_d    = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
            ram_cnt_d = ram_cnt_q + CW'(1);
            prio_d    = PRIO_READ;
        end
        if (rd_go) begin
            rptr_d    = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
            ram_cnt_d = ram_cnt_q - CW'(1);
            prio_d    = PRIO_WRITE;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            prio_q        <= PRIO_READ;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            prio_q        <= prio_d;
        end
    end

    assign ob_pop = pop_valid && pop_ready;

    spram_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight_q),
        .push_data (mem_rdata),
        .pop       (ob_pop),
        .cnt       (ob_cnt),
        .head      (pop_data)
    );

    assign pop_valid = (ob_cnt != '0);
    assign level     = LW'(ram_cnt_q) + LW'(ob_pending);
    assign mem_wen   = wr_go;
    assign mem_ren   = rd_go;
    assign mem_waddr = wptr_q;
    assign mem_raddr = rptr_q;
    assign mem_wdata = push_data;

    a_port_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_wen && mem_ren));

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl: two instances (DEPTH=32 and DEPTH=5) share stimulus,
// each backed by its own RAM stand-in; one is checked at a time against a queue model.
module tb_spram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pv = 1'b0;
    logic [15:0] pd = '0;
    logic        pr = 1'b0;

    logic        a_prdy, a_pval, a_wen, a_ren;
    logic [15:0] a_pdat, a_wd, a_rd;
    logic [5:0]  a_lvl;
    logic [4:0]  a_wa, a_ra;

    logic        b_prdy, b_pval, b_wen, b_ren;
    logic [15:0] b_pdat, b_wd, b_rd;
    logic [2:0]  b_lvl;
    logic [2:0]  b_wa, b_ra;

    logic [15:0] ram_a [32];
    logic [15:0] ram_b [5];

    always #5 clk = ~clk;

    spram_fifo_ctrl #(.WIDTH(16), .DEPTH(32)) u_dut (
        .clk(clk), .rst(rst), .push_valid(pv), .push_ready(a_prdy), .push_data(pd),
        .pop_valid(a_pval), .pop_ready(pr), .pop_data(a_pdat), .level(a_lvl),
        .mem_wen(a_wen), .mem_ren(a_ren), .mem_waddr(a_wa), .mem_raddr(a_ra),
        .mem_wdata(a_wd), .mem_rdata(a_rd)
    );

    spram_fifo_ctrl #(.WIDTH(16), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .push_valid(pv), .push_ready(b_prdy), .push_data(pd),
        .pop_valid(b_pval), .pop_ready(pr), .pop_data(b_pdat), .level(b_lvl),
        .mem_wen(b_wen), .mem_ren(b_ren), .mem_waddr(b_wa), .mem_raddr(b_ra),
        .mem_wdata(b_wd), .mem_rdata(b_rd)
    );

    // Single-port RAM stand-ins: 1-cycle write, read data valid the cycle after ren,
    // garbage otherwise so an unwanted capture shows up.
    always @(posedge clk) begin
        if (a_wen) ram_a[a_wa] <= a_wd;
        a_rd <= a_ren ? ram_a[a_ra] : 16'($urandom);
        if (b_wen && b_wa < 3'd5) ram_b[b_wa] <= b_wd;
        b_rd <= (b_ren && b_ra < 3'd5) ? ram_b[b_ra] : 16'($urandom);
    end

    int total = 0;
    int bad = 0;

    // Reference model: contents as queues, occupancy by plain counting.
    bit          sel;
    int          md, wp, rp, inf, cyc;
    bit          prio_w;
    logic [15:0] infd;
    logic [15:0] ramq[$];
    logic [15:0] obq[$];

    // Observations
    int          o_pr, o_pv, o_pd, o_lvl, o_wen, o_ren, o_wa, o_ra, o_wd;
    logic [15:0] popped[$];
    bit          last_acc, last_ren;
    int          first_pv, maxlvl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pv = 1'b0; pr = 1'b0;
        @(posedge clk);
        ramq.delete(); obq.delete();
        inf = 0; wp = 0; rp = 0; prio_w = 1'b0;
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit r);
        bit rdq, e_pr, wg, rg;
        @(negedge clk);
        rst = 1'b0; pv = v; pd = d; pr = r;
        #1;
        if (sel) begin
            o_pr = b_prdy; o_pv = b_pval; o_pd = b_pdat; o_lvl = b_lvl;
            o_wen = b_wen; o_ren = b_ren; o_wa = b_wa; o_ra = b_ra; o_wd = b_wd;
        end else begin
            o_pr = a_prdy; o_pv = a_pval; o_pd = a_pdat; o_lvl = a_lvl;
            o_wen = a_wen; o_ren = a_ren; o_wa = a_wa; o_ra = a_ra; o_wd = a_wd;
        end
        rdq  = (ramq.size() != 0) && (obq.size() + inf < 2);
        e_pr = (ramq.size() != md) && !(rdq && !prio_w);
        wg   = v && e_pr;
        rg   = rdq && !wg;
        chk("push_ready", o_pr, e_pr);
        chk("pop_valid", o_pv, obq.size() != 0);
        if (obq.size() != 0) chk("pop_data", o_pd, obq[0]);
        chk("level", o_lvl, ramq.size() + inf + obq.size());
        chk("mem_wen", o_wen, wg);
        chk("mem_ren", o_ren, rg);
        chk("mem_waddr", o_wa, wp);
        chk("mem_raddr", o_ra, rp);
        if (wg) chk("mem_wdata", o_wd, d);
        if (o_pv != 0 && r) popped.push_back(16'(o_pd));
        if (o_pv != 0 && first_pv < 0) first_pv = cyc;
        if (o_lvl > maxlvl) maxlvl = o_lvl;
        last_acc = (o_pr != 0) && v;
        last_ren = (o_ren != 0);
        @(posedge clk);
        if (obq.size() != 0 && r) void'(obq.pop_front());
        if (inf != 0) obq.push_back(infd);
        inf = rg ? 1 : 0;
        if (rg) begin infd = ramq.pop_front(); rp = (rp + 1) % md; end
        if (wg) begin ramq.push_back(d); wp = (wp + 1) % md; end
        if (rg) prio_w = 1'b1;
        else if (wg) prio_w = 1'b0;
        cyc++;
    endtask

    initial begin
        int t0, nxt, nacc, nalt, nwa4, pwen;
        logic [15:0] dat;
        cyc = 0; sel = 1'b0; md = 32; first_pv = -1; maxlvl = 0;

        // Reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0);
        chk("idle_push_ready", o_pr, 1);
        chk("idle_level", o_lvl, 0);

        // Single word latency
        popped.delete(); first_pv = -1;
        t0 = cyc;
        step(1'b1, 16'hA5A5, 1'b1);
        chk("single_wen", o_wen, 1);
        step(1'b0, 16'h0, 1'b1);
        chk("single_ren", o_ren, 1);
        chk("single_raddr", o_ra, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        chk("single_latency", first_pv - t0, 3);
        chk("single_count", popped.size(), 1);
        if (popped.size() == 1) chk("single_data", popped[0], 16'hA5A5);
        chk("single_level_end", o_lvl, 0);

        // Fill with consumer stalled, then drain
        do_reset();
        popped.delete(); nxt = 1; nacc = 0;
        for (int c = 0; c < 60; c++) begin
            step(nxt <= 40, 16'(nxt), 1'b0);
            if (last_acc) begin nxt++; nacc++; end
        end
        chk("fill_accepted", nacc, 34);
        chk("fill_level", o_lvl, 34);
        chk("fill_push_ready", o_pr, 0);
        chk("fill_ptrs_equal", o_wa, o_ra);
        for (int c = 0; c < 150; c++) step(1'b0, 16'h0, 1'b1);
        chk("fill_drained", popped.size(), 34);
        for (int i = 0; i < popped.size() && i < 34; i++) chk("fill_order", popped[i], 16'(i + 1));

        // Both sides saturated
        do_reset();
        maxlvl = 0; nalt = 0; pwen = -1; dat = 16'($urandom);
        for (int c = 0; c < 200; c++) begin
            step(1'b1, dat, 1'b1);
            if (last_acc) dat = 16'($urandom);
            if (c >= 2 && o_wen == pwen) nalt++;
            if (o_wen != 0 && o_ren != 0) nalt++;
            pwen = o_wen;
        end
        chk("sat_alternate", nalt, 0);
        chk("sat_level_max", maxlvl <= 3, 1);

        // Wrap with DEPTH=5 and random consumer
        sel = 1'b1; md = 5;
        do_reset();
        popped.delete(); nxt = 0; nwa4 = 0;
        for (int c = 0; c < 600 && popped.size() < 20; c++) begin
            step(nxt < 20, 16'(nxt), 1'($urandom_range(0, 1)));
            if (last_acc) nxt++;
            if (o_wen != 0 && o_wa == 4) nwa4++;
        end
        chk("wrap_count", popped.size(), 20);
        chk("wrap_last_addr_hits", nwa4, 4);
        for (int i = 0; i < popped.size() && i < 20; i++) chk("wrap_order", popped[i], 16'(i));

        // Reset right after a RAM read is issued
        sel = 1'b0; md = 32;
        do_reset();
        last_ren = 1'b0;
        for (int c = 0; c < 20 && !last_ren; c++) step(1'b1, 16'(16'h1000 + c), 1'b0);
        chk("rst_ren_seen", last_ren, 1);
        do_reset();
        step(1'b0, 16'h0, 1'b1);
        chk("rst_level", o_lvl, 0);
        chk("rst_pop_valid", o_pv, 0);
        for (int c = 0; c < 4; c++) step(1'b0, 16'h0, 1'b1);
        chk("rst_still_empty", o_pv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
